uart_rx_buffer: RTL and testbench

Receive-side buffer directly downstream of the UART receiver. Captures each byte presented with a one-`clk` `rx_status` strobe into a small FIFO, so bytes are not lost while the CPU is busy. Exposes a first-word-fall-through read port, occupancy, a sticky overflow flag and a level interrupt to the CPU's peripheral bus logic.

---
 rtl/uart_pkg.sv | 10 +
 rtl/uart_fifo_mem.sv | 25 ++
 rtl/uart_rx_buffer.sv | 75 +++++++
 tb/tb_uart_rx_buffer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and types.
// Used by the receive buffer and its storage array.
package uart_pkg;
  localparam int UART_DATA_W = 8;
  localparam int UART_RXBUF_DEPTH = 8;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

  localparam uart_byte_t UART_EMPTY_BYTE = 8'h00;
endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTHx8 register array: one synchronous write port,
// one asynchronous read port. Contents are not reset.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_RXBUF_DEPTH,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  uart_byte_t    wdata,
  input  logic [AW-1:0] raddr,
  output uart_byte_t    rdata
);

  uart_byte_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_buffer.sv
// Receive byte FIFO behind the UART receiver.
// First-word-fall-through read, sticky overflow, level irq.
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_RXBUF_DEPTH,
  parameter int AW = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_status,
  input  logic        rd_en,
  input  logic        clr_ovf,
  output logic [7:0]  rd_data,
  output logic        empty,
  output logic        full,
  output logic [AW:0] count,
  output logic        overflow,
  output logic        irq
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic          ovf_q;
  logic          push;
  logic          pop;
  logic          drop;
  uart_byte_t    mem_rdata;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);
  assign pop   = rd_en & ~empty;
  // A pop frees the slot in the same cycle, so a full
  // buffer still accepts a byte when read concurrently.
  assign push  = rx_status & (~full | pop);
  assign drop  = rx_status & ~push;

  uart_fifo_mem #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr),
    .wdata(rx_data),
    .raddr(rd_ptr),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      if (drop)         ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
    end
  end

  assign rd_data  = empty ? UART_EMPTY_BYTE : mem_rdata;
  assign count    = count_q;
  assign overflow = ovf_q;
  assign irq      = ~empty;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed bench for uart_rx_buffer with hand-computed
// expectations checked by immediate assertions.
module tb_uart_rx_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_status;
  logic       rd_en;
  logic       clr_ovf;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       overflow;
  logic       irq;

  int n_chk = 0;
  int n_fail = 0;

  uart_rx_buffer #(.DEPTH(8), .AW(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_status(rx_status),
    .rd_en    (rd_en),
    .clr_ovf  (clr_ovf),
    .rd_data  (rd_data),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and checks run 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_rdata"}, 32'(rd_data), 32'h00);
    chk({tag, "_irq"}, 32'(irq), 32'd0);
    chk({tag, "_full"}, 32'(full), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    rx_data = 8'h00;
    rx_status = 1'b0;
    rd_en = 1'b0;
    clr_ovf = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk_idle("rst");
    chk("rst_ovf", 32'(overflow), 32'd0);

    // pop on empty is ignored
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk_idle("under");

    // three pushes
    rx_status = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_data = 8'h41 + 8'(i);
      tick();
      chk("p3_count", 32'(count), 32'(i + 1));
      chk("p3_head", 32'(rd_data), 32'h41);
    end
    rx_status = 1'b0;
    chk("p3_irq", 32'(irq), 32'd1);

    // three back-to-back pops
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("pop3_data", 32'(rd_data), 32'(8'h41 + 8'(i)));
      chk("pop3_irq", 32'(irq), 32'd1);
      tick();
      chk("pop3_count", 32'(count), 32'(2 - i));
    end
    rd_en = 1'b0;
    chk_idle("pop3_end");

    // fill A0..A7
    rx_status = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data = 8'hA0 + 8'(i);
      tick();
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd8);
    chk("fill_ovf", 32'(overflow), 32'd0);

    // dropped byte
    rx_data = 8'hFF;
    tick();
    rx_status = 1'b0;
    chk("drop_ovf", 32'(overflow), 32'd1);
    chk("drop_count", 32'(count), 32'd8);
    chk("drop_head", 32'(rd_data), 32'hA0);

    // push and pop together while full
    rx_status = 1'b1;
    rx_data = 8'h55;
    rd_en = 1'b1;
    chk("both_head", 32'(rd_data), 32'hA0);
    tick();
    rx_status = 1'b0;
    rd_en = 1'b0;
    chk("both_count", 32'(count), 32'd8);
    chk("both_ovf", 32'(overflow), 32'd1);
    chk("both_head2", 32'(rd_data), 32'hA1);

    // clear and new overflow in the same cycle: set wins
    rx_status = 1'b1;
    rx_data = 8'hEE;
    clr_ovf = 1'b1;
    tick();
    rx_status = 1'b0;
    chk("clrset_ovf", 32'(overflow), 32'd1);
    chk("clrset_count", 32'(count), 32'd8);
    tick();
    clr_ovf = 1'b0;
    chk("clr_ovf", 32'(overflow), 32'd0);

    // drain: A1..A7 then 55
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_data", 32'(rd_data),
          (i < 7) ? 32'(8'hA1 + 8'(i)) : 32'h55);
      tick();
    end
    rd_en = 1'b0;
    chk_idle("drain_end");

    // push and pop together while empty: only the push happens
    rx_status = 1'b1;
    rx_data = 8'h77;
    rd_en = 1'b1;
    tick();
    rx_status = 1'b0;
    rd_en = 1'b0;
    chk("emp_both_count", 32'(count), 32'd1);
    chk("emp_both_data", 32'(rd_data), 32'h77);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("emp_both_drain", 32'(count), 32'd0);

    // wrap-around: 20 bytes, pops lag pushes by two
    for (int i = 0; i < 22; i++) begin
      rx_status = (i < 20);
      rx_data = 8'(i);
      rd_en = (i >= 2);
      if (i >= 2)
        chk("wrap_data", 32'(rd_data), 32'(i - 2));
      tick();
      chk("wrap_occ", 32'(count <= 4'd3), 32'd1);
    end
    rx_status = 1'b0;
    rd_en = 1'b0;
    chk("wrap_end", 32'(count), 32'd0);

    // reset with three bytes held
    rx_status = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_data = 8'hC0 + 8'(i);
      tick();
    end
    rx_status = 1'b0;
    chk("prerst_count", 32'(count), 32'd3);
    reset = 1'b1;
    #1;
    chk("async_count", 32'(count), 32'd0);
    tick();
    reset = 1'b0;
    chk_idle("midrst");
    chk("midrst_ovf", 32'(overflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
